// File: rtl/idct4_pipe_if.sv
// Stream interface of the 4-point transform core: one 4-sample vector per beat in,
// one 4-sample result vector per beat out.
interface idct4_pipe_if #(
    parameter int DW = 25,
    parameter int OW = 16
);
    // Both sides use valid/ready: a beat moves on a rising edge where valid and ready
    // are both 1; valid and its payload hold until that happens; ready may depend on
    // the state of the receiver but never on the valid it is paired with.
    logic                 in_valid;
    logic                 in_ready;
    logic                 mode;
    logic signed [DW-1:0] d_in_1;
    logic signed [DW-1:0] d_in_2;
    logic signed [DW-1:0] d_in_3;
    logic signed [DW-1:0] d_in_4;
    logic                 out_valid;
    logic                 out_ready;
    logic signed [OW-1:0] d_out_1;
    logic signed [OW-1:0] d_out_2;
    logic signed [OW-1:0] d_out_3;
    logic signed [OW-1:0] d_out_4;

    modport master (
        output in_valid, mode, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
        input  in_ready, out_valid, d_out_1, d_out_2, d_out_3, d_out_4
    );

    modport slave (
        input  in_valid, mode, d_in_1, d_in_2, d_in_3, d_in_4, out_ready,
        output in_ready, out_valid, d_out_1, d_out_2, d_out_3, d_out_4
    );
endinterface

// File: rtl/idct4_pipe.sv
// Three-stage pipelined 4-point integer transform (inverse or forward per beat),
// with round, shift and saturate on the output and a single global stall.
module idct4_pipe #(
    parameter int DW    = 25,
    parameter int OW    = 16,
    parameter int SHIFT = 7
) (
    input  logic        clk,
    input  logic        reset,
    idct4_pipe_if.slave io
);
    localparam int W = DW + 10;
    localparam logic signed [W-1:0] RND = W'(1) <<< (SHIFT - 1);
    localparam logic signed [W-1:0] HI  = {{(W-OW+1){1'b0}}, {(OW-1){1'b1}}};
    localparam logic signed [W-1:0] LO  = {{(W-OW+1){1'b1}}, {(OW-1){1'b0}}};
    localparam logic signed [W-1:0] K83 = W'(83);
    localparam logic signed [W-1:0] K36 = W'(36);

    function automatic logic signed [OW-1:0] rnd_sat(input logic signed [W-1:0] y);
        logic signed [W-1:0] r;
        r = (y + RND) >>> SHIFT;
        if (r > HI)      rnd_sat = HI[OW-1:0];
        else if (r < LO) rnd_sat = LO[OW-1:0];
        else             rnd_sat = r[OW-1:0];
    endfunction

    // Whole pipeline moves together; an empty output stage never blocks.
    logic adv;
    assign adv         = !io.out_valid || io.out_ready;
    assign io.in_ready = adv;

    logic signed [W-1:0] x0, x1, x2, x3;
    assign x0 = {{(W-DW){io.d_in_1[DW-1]}}, io.d_in_1};
    assign x1 = {{(W-DW){io.d_in_2[DW-1]}}, io.d_in_2};
    assign x2 = {{(W-DW){io.d_in_3[DW-1]}}, io.d_in_3};
    assign x3 = {{(W-DW){io.d_in_4[DW-1]}}, io.d_in_4};

    logic                v1, m1, v2, m2;
    logic signed [W-1:0] a0, a1, a2, a3;
    logic signed [W-1:0] b0, b1, b2, b3;
    logic signed [W-1:0] y0, y1, y2, y3;

    // S1 butterflies; a2/a3 carry the odd inputs in both modes so S2 shares one odd path.
    always_ff @(posedge clk) begin
        if (reset) begin
            v1 <= 1'b0;
        end else if (adv) begin
            v1 <= io.in_valid;
            m1 <= io.mode;
            a0 <= io.mode ? x0 + x3 : x0 + x2;
            a1 <= io.mode ? x1 + x2 : x0 - x2;
            a2 <= io.mode ? x0 - x3 : x1;
            a3 <= io.mode ? x1 - x2 : x3;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            v2 <= 1'b0;
        end else if (adv) begin
            v2 <= v1;
            m2 <= m1;
            b0 <= m1 ? (a0 + a1) <<< 6 : a0 <<< 6;
            b1 <= m1 ? (a0 - a1) <<< 6 : a1 <<< 6;
            b2 <= a2 * K83 + a3 * K36;
            b3 <= a2 * K36 - a3 * K83;
        end
    end

    // Forward mode reorders (A, B, C, D) into (y0, y2, y1, y3).
    always_comb begin
        y0 = m2 ? b0 : b0 + b2;
        y1 = m2 ? b2 : b1 + b3;
        y2 = m2 ? b1 : b1 - b3;
        y3 = m2 ? b3 : b0 - b2;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            io.out_valid <= 1'b0;
            io.d_out_1   <= '0;
            io.d_out_2   <= '0;
            io.d_out_3   <= '0;
            io.d_out_4   <= '0;
        end else if (adv) begin
            io.out_valid <= v2;
            io.d_out_1   <= rnd_sat(y0);
            io.d_out_2   <= rnd_sat(y1);
            io.d_out_3   <= rnd_sat(y2);
            io.d_out_4   <= rnd_sat(y3);
        end
    end
endmodule

// File: tb/tb_idct4_pipe.sv
// Scoreboard bench for idct4_pipe: directed vectors with hand-derived results, a
// randomly stalled stream checked against a matrix-form model, and a mid-stream reset.
module tb_idct4_pipe;
    localparam int DW    = 25;
    localparam int OW    = 16;
    localparam int SHIFT = 7;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    idct4_pipe_if #(.DW(DW), .OW(OW)) bus();
    idct4_pipe #(.DW(DW), .OW(OW), .SHIFT(SHIFT)) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [4*OW-1:0] exp_q[$];
    int              lat_q[$];
    logic            bp_en   = 1'b0;
    logic            rdy_cmd = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    // out_ready has a single driver: random while bp_en, else follows rdy_cmd.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready = bp_en ? 1'($urandom_range(0, 1)) : rdy_cmd;
        end
    end

    function automatic logic [4*OW-1:0] pk(input int y0, input int y1, input int y2, input int y3);
        return {OW'(y3), OW'(y2), OW'(y1), OW'(y0)};
    endfunction

    function automatic int rs(input longint y);
        longint r;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (OW - 1)) - 1;
        lo = -(longint'(1) <<< (OW - 1));
        r  = (y + (longint'(1) <<< (SHIFT - 1))) >>> SHIFT;
        if (r > hi) r = hi;
        if (r < lo) r = lo;
        return int'(r);
    endfunction

    // Direct matrix form of the two transforms.
    function automatic logic [4*OW-1:0] model(input logic m, input longint x0, input longint x1,
                                              input longint x2, input longint x3);
        longint y0, y1, y2, y3;
        if (!m) begin
            y0 = 64*x0 + 83*x1 + 64*x2 + 36*x3;
            y1 = 64*x0 + 36*x1 - 64*x2 - 83*x3;
            y2 = 64*x0 - 36*x1 - 64*x2 + 83*x3;
            y3 = 64*x0 - 83*x1 + 64*x2 - 36*x3;
        end else begin
            y0 = 64*(x0 + x1 + x2 + x3);
            y1 = 83*(x0 - x3) + 36*(x1 - x2);
            y2 = 64*(x0 - x1 - x2 + x3);
            y3 = 36*(x0 - x3) - 83*(x1 - x2);
        end
        return pk(rs(y0), rs(y1), rs(y2), rs(y3));
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic send(input logic m, input longint x0, input longint x1, input longint x2,
                        input longint x3, input logic [4*OW-1:0] e, input logic chk_lat,
                        input logic expect_out);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.mode     = m;
        bus.d_in_1   = DW'(x0);
        bus.d_in_2   = DW'(x1);
        bus.d_in_3   = DW'(x2);
        bus.d_in_4   = DW'(x3);
        @(negedge clk);
        while (!bus.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: in_ready got 0 required 1");
        end else if (expect_out) begin
            exp_q.push_back(e);
            lat_q.push_back(chk_lat ? cyc : -1);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            n++;
            @(negedge clk);
        end
        check("drain_pending", exp_q.size(), 0);
    endtask

    // Monitor: pops on each consumed output, and checks hold behaviour during stalls.
    logic            hold_v = 1'b0;
    logic [4*OW-1:0] hold_d;
    always @(negedge clk) begin
        logic [4*OW-1:0] dout;
        logic [4*OW-1:0] e;
        int              l;
        dout = {bus.d_out_4, bus.d_out_3, bus.d_out_2, bus.d_out_1};
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) begin
                total++;
                if (!bus.out_valid || dout !== hold_d) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b d=%h required v=1 d=%h",
                             bus.out_valid, dout, hold_d);
                end
            end
            if (bus.out_valid && !bus.out_ready) begin
                check("stall_in_ready", bus.in_ready, 0);
                hold_v = 1'b1;
                hold_d = dout;
            end else begin
                hold_v = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out: got d=%h required no output", dout);
                end else begin
                    e = exp_q.pop_front();
                    l = lat_q.pop_front();
                    total++;
                    if (dout !== e) begin
                        bad++;
                        $display("FAIL out_data: got %h required %h", dout, e);
                    end
                    if (l >= 0) check("latency", cyc - l, 3);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        bus.d_in_1   = '0;
        bus.d_in_2   = '0;
        bus.d_in_3   = '0;
        bus.d_in_4   = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_d_out_1", bus.d_out_1, 0);
        check("rst_d_out_4", bus.d_out_4, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;

        // Directed vectors, no stalls, so every latency is checked.
        send(1'b0, -720, 0, 0, 0, pk(-360, -360, -360, -360), 1'b1, 1'b1);
        send(1'b0, 0, 1440, 0, 0, pk(934, 405, -405, -934), 1'b1, 1'b1);
        send(1'b1, 10, 20, 30, 40, pk(50, -22, 0, -2), 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            send(1'b1, 1, 1, 1, 1, pk(2, 0, 0, 0), 1'b1, 1'b1);
            send(1'b0, -720, 0, 0, 0, pk(-360, -360, -360, -360), 1'b1, 1'b1);
        end
        send(1'b0, 16777215, 0, 0, 0, pk(32767, 32767, 32767, 32767), 1'b1, 1'b1);
        send(1'b0, -16777216, 0, 0, 0, pk(-32768, -32768, -32768, -32768), 1'b1, 1'b1);
        drain();

        // Random gaps on the input and random back-pressure on the output.
        bp_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            longint r0, r1, r2, r3;
            logic   rm;
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
            r0 = longint'($urandom_range(0, 4000)) - 2000;
            r1 = longint'($urandom_range(0, 4000)) - 2000;
            r2 = longint'($urandom_range(0, 4000)) - 2000;
            r3 = longint'($urandom_range(0, 4000)) - 2000;
            rm = 1'($urandom_range(0, 1));
            send(rm, r0, r1, r2, r3, model(rm, r0, r1, r2, r3), 1'b0, 1'b1);
        end
        drain();
        bp_en   = 1'b0;
        rdy_cmd = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Fill all three stages while blocked, then reset: nothing may emerge.
        send(1'b0, 100, 200, 300, 400, '0, 1'b0, 1'b0);
        send(1'b1, 500, 600, 700, 800, '0, 1'b0, 1'b0);
        send(1'b0, -720, 0, 0, 0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_out_valid", bus.out_valid, 0);
        check("mid_rst_d_out_1", bus.d_out_1, 0);
        check("mid_rst_d_out_2", bus.d_out_2, 0);
        check("mid_rst_d_out_3", bus.d_out_3, 0);
        check("mid_rst_d_out_4", bus.d_out_4, 0);
        check("mid_rst_in_ready", bus.in_ready, 1);
        rdy_cmd = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("no_stale_out_valid", bus.out_valid, 0);
        send(1'b0, 0, 1440, 0, 0, pk(934, 405, -405, -934), 1'b1, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
